// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: default polynomial, checker state encoding and the
// one-step LFSR advance used by both generator and checker.
package prbs_pkg;

   localparam int          PRBS_N    = 14;
   localparam logic [13:0] PRBS_TAPS = 14'h3802;  // x^14+x^13+x^12+x^2+1

   typedef enum logic {HUNT, LOCKED} chk_state_t;

   function automatic logic [PRBS_N-1:0] prbs_next(input logic [PRBS_N-1:0] word,
                                                   input logic [PRBS_N-1:0] taps);
      return {word[PRBS_N-2:0], ^(word & taps)};
   endfunction

endpackage

// File: rtl/prbs_step.sv
// One LFSR step: shift left, feedback is the parity of the tapped bits.
module prbs_step #(
   parameter int             N    = 14,
   parameter logic [N-1:0]   TAPS = 14'h3802
) (
   input  logic [N-1:0] word_i,
   output logic [N-1:0] next_o
);

   assign next_o = {word_i[N-2:0], ^(word_i & TAPS)};

endmodule

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS checker: predicts each word from the previous one,
// tracks lock with hysteresis and counts mismatches seen while locked.
module prbs_chk
   import prbs_pkg::*;
#(
   parameter int           N        = 14,
   parameter logic [N-1:0] TAPS     = PRBS_TAPS,
   parameter int           LOCK_CNT = 8,
   parameter int           MISS_MAX = 4,
   parameter int           CW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  rnd_bus,
   input  logic          in_valid,
   input  logic          err_clr,
   output logic          locked,
   output logic          err_pulse,
   output logic [CW-1:0] err_cnt,
   output logic          zero_det
);

   logic [N-1:0]  prev_word_q;
   logic [N-1:0]  pred;
   logic          prev_ok_q;
   chk_state_t    state_q, state_d;
   logic [7:0]    run_q, run_d;
   logic [7:0]    mcnt_q, mcnt_d;
   logic [CW-1:0] err_cnt_q, err_cnt_d;
   logic          err_pulse_q, err_pulse_d;
   logic          zero_det_q;
   logic          is_zero, match, miss;

   prbs_step #(.N(N), .TAPS(TAPS)) u_step (
      .word_i (prev_word_q),
      .next_o (pred)
   );

   // All-zero is the LFSR lock-up state, so it can never be a valid match.
   assign is_zero = (rnd_bus == '0);
   assign match   = in_valid & prev_ok_q & ~is_zero & (rnd_bus == pred);
   assign miss    = in_valid & prev_ok_q & ~match;

   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      mcnt_d      = mcnt_q;
      err_cnt_d   = err_cnt_q;
      err_pulse_d = 1'b0;
      case (state_q)
         HUNT: begin
            if (match) begin
               if (run_q == 8'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 8'd1;
               end
            end else if (miss) begin
               run_d = '0;
            end
         end
         LOCKED: begin
            if (miss) begin
               err_pulse_d = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
               if (mcnt_q == 8'(MISS_MAX - 1)) begin
                  state_d = HUNT;
                  mcnt_d  = '0;
                  run_d   = '0;
               end else begin
                  mcnt_d = mcnt_q + 8'd1;
               end
            end else if (match) begin
               mcnt_d = '0;
            end
         end
         default: state_d = HUNT;
      endcase
      if (err_clr) err_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         run_q       <= '0;
         mcnt_q      <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         zero_det_q  <= 1'b0;
         prev_word_q <= '0;
         prev_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         mcnt_q      <= mcnt_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         if (in_valid) begin
            prev_word_q <= rnd_bus;
            prev_ok_q   <= 1'b1;
            zero_det_q  <= is_zero;
         end
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign zero_det  = zero_det_q;

endmodule

// File: tb/tb_prbs_chk.sv
// Randomised bench for prbs_chk: a behavioural model tracks lock/error state
// and every cycle's outputs are compared against it.
module tb_prbs_chk;

   localparam int           N    = 14;
   localparam int           LOCK = 8;
   localparam int           MISS = 4;
   localparam int           CW   = 4;
   localparam int           EMAX = (1 << CW) - 1;
   localparam logic [N-1:0] TAPS = 14'h3802;

   logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
   logic [N-1:0]  rnd_bus = '0;
   logic          locked, err_pulse, zero_det;
   logic [CW-1:0] err_cnt;
   int            checks = 0, failures = 0;

   prbs_chk #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK), .MISS_MAX(MISS), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .rnd_bus(rnd_bus), .in_valid(in_valid),
      .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .zero_det(zero_det)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] ref_next(input logic [N-1:0] w);
      int ones;
      ones = $countones(w & TAPS);
      return (w << 1) | N'(ones % 2);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural reference
   bit           m_locked = 0, m_pulse = 0, m_zero = 0, m_have = 0, m_ok, m_bad;
   int           m_err = 0, m_run = 0, m_miss = 0;
   logic [N-1:0] m_prev = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_locked = 0; m_pulse = 0; m_zero = 0; m_have = 0;
         m_err = 0; m_run = 0; m_miss = 0; m_prev = '0;
      end else begin
         m_pulse = 0;
         if (in_valid) begin
            m_ok  = m_have && (rnd_bus == ref_next(m_prev)) && (rnd_bus != 0);
            m_bad = m_have && !m_ok;
            if (!m_locked) begin
               if (m_ok) m_run++;
               else if (m_bad) m_run = 0;
               if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
            end else if (m_bad) begin
               m_pulse = 1;
               if (m_err < EMAX) m_err++;
               m_miss++;
               if (m_miss == MISS) begin m_locked = 0; m_miss = 0; m_run = 0; end
            end else if (m_ok) begin
               m_miss = 0;
            end
            m_prev = rnd_bus; m_have = 1; m_zero = (rnd_bus == 0);
         end
         if (err_clr) m_err = 0;
      end
   end

   always @(negedge clk) begin
      chk("locked", 32'(locked), 32'(m_locked));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("zero_det", 32'(zero_det), 32'(m_zero));
   end

   logic [N-1:0] g;

   task automatic send(input logic [N-1:0] w, input bit v, input bit clr);
      rnd_bus = w; in_valid = v; err_clr = clr;
      @(posedge clk); #1;
      in_valid = 0; err_clr = 0;
   endtask

   task automatic clean(input int n);
      repeat (n) begin send(g, 1, 0); g = ref_next(g); end
   endtask

   task automatic flip(input logic [N-1:0] mask, input bit clr);
      send(g ^ mask, 1, clr); g = ref_next(g);
   endtask

   task automatic reset_outputs_chk(input string tag);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_pulse"}, 32'(err_pulse), 0);
      chk({tag, "_err"}, 32'(err_cnt), 0);
      chk({tag, "_zero"}, 32'(zero_det), 0);
   endtask

   initial begin
      int nv, cyc, r;
      // pin the model's LFSR step
      chk("next_0001", 32'(ref_next(14'h0001)), 32'h0002);
      chk("next_3802", 32'(ref_next(14'h3802)), 32'h3004);
      chk("next_2000", 32'(ref_next(14'h2000)), 32'h0001);

      #12 reset_outputs_chk("por");
      @(posedge clk); #1 rst_n = 1;

      // clean stream from 0x0001: lock after LOCK+1 words
      g = 14'h0001;
      clean(LOCK);
      chk("not_yet_locked", 32'(locked), 0);
      clean(1);
      chk("locked_first", 32'(locked), 1);
      clean(190);
      chk("clean_err", 32'(err_cnt), 0);

      // single bit flip -> two errors, lock kept
      flip(14'h0008, 0);
      clean(1);
      chk("flip_err", 32'(err_cnt), 2);
      chk("flip_locked", 32'(locked), 1);
      clean(3);

      // burst of 4 wrong words drops lock, relock 9 words later
      send(g, 1, 1); g = ref_next(g);
      chk("clr_err", 32'(err_cnt), 0);
      repeat (3) flip(14'h0001, 0);
      chk("burst3_locked", 32'(locked), 1);
      flip(14'h0001, 0);
      chk("burst_err", 32'(err_cnt), 4);
      chk("burst_unlocked", 32'(locked), 0);
      clean(8);
      chk("relock_early", 32'(locked), 0);
      clean(1);
      chk("relock", 32'(locked), 1);
      chk("relock_err", 32'(err_cnt), 4);

      // clear coincident with a counted miss
      clean(5);
      flip(14'h0008, 0);
      chk("pre_clr_err", 32'(err_cnt), 5);
      flip(14'h0008, 1);
      chk("clr_wins", 32'(err_cnt), 0);
      clean(1);
      chk("post_clr_err", 32'(err_cnt), 1);

      // saturation
      clean(2);
      repeat (10) begin flip(14'h0008, 0); clean(3); end
      chk("sat_err", 32'(err_cnt), EMAX);
      chk("sat_locked", 32'(locked), 1);

      // asynchronous reset mid-lock
      @(posedge clk); #3 rst_n = 0;
      #1 reset_outputs_chk("async");
      @(posedge clk); #1 rst_n = 1;

      // all-zero words never lock
      repeat (20) send('0, 1, 0);
      chk("zero_det", 32'(zero_det), 1);
      chk("zero_locked", 32'(locked), 0);
      chk("zero_err", 32'(err_cnt), 0);

      // 50% valid on a clean stream seeded at 0x3802
      g = 14'h3802; nv = 0; cyc = 0;
      while (nv < 40 && cyc < 400) begin
         if ($urandom_range(0, 1) == 1) begin send(g, 1, 0); g = ref_next(g); nv++; end
         else send(N'($urandom), 0, 0);
         cyc++;
      end
      chk("gap_valid_words", 32'(nv), 40);
      chk("gap_locked", 32'(locked), 1);
      chk("gap_err", 32'(err_cnt), 0);

      // randomised mix, model-checked every cycle
      repeat (3000) begin
         r = $urandom_range(0, 99);
         if (r < 8)       send(N'($urandom), 0, 0);
         else if (r < 12) flip(N'($urandom_range(1, (1 << N) - 1)), 0);
         else if (r < 13) send('0, 1, 0);
         else if (r < 15) begin send(g, 1, 1); g = ref_next(g); end
         else if (r < 16) begin g = N'($urandom_range(1, (1 << N) - 1)); clean(1); end
         else clean(1);
      end

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs_chk.md
# prbs_chk

Self-synchronising PRBS checker: the receive end of the `prbs` generator's `rnd_bus`. Each clock it takes one N-bit word, predicts the next word from it using the same LFSR step, and compares. It reports lock status and a saturating error count, plus a one-cycle error pulse. It sits at the far end of a link or loopback under test and needs no seed.

## Interface
Parameters:
- `N`, 14: word and LFSR width; must match the generator.
- `TAPS`, 14'h3802: feedback tap mask, x^14+x^13+x^12+x^2+1. Feedback bit = XOR-reduce(word & TAPS).
- `LOCK_CNT`, 8: consecutive matches needed to declare lock, 1..255.
- `MISS_MAX`, 4: consecutive mismatches that drop lock, 1..255.
- `CW`, 16: error-counter width.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `rnd_bus`  in  N: received PRBS word.
- `in_valid`  in  1: `rnd_bus` is sampled only on cycles where this is high.
- `err_clr`  in  1: synchronous clear of `err_cnt`.
- `locked`  out  1: high while in LOCKED.
- `err_pulse`  out  1: one-cycle pulse per mismatch counted while LOCKED.
- `err_cnt`  out  CW: saturating count of mismatches seen while LOCKED.
- `zero_det`  out  1: last accepted word was all-zero (LFSR lock-up state).

## Operation
- Generator model: state shifts left by one per clock. Next word = {w[N-2:0], ^(w & TAPS)}.
- Checker keeps `prev_word` and `prev_ok`. `prev_ok` means a previous accepted word exists.
- Prediction `pred = next(prev_word)`.
- `match` = in_valid & prev_ok & (rnd_bus == pred).
- `miss` = in_valid & prev_ok & ~match.
- On every accepted word, `prev_word` <= rnd_bus and `prev_ok` <= 1. An all-zero word is treated as `miss`, whatever the prediction.
- FSM states:
  - HUNT: run counter `run` counts matches and is cleared by a miss. When `run` reaches LOCK_CNT, go to LOCKED and clear `run`.
  - LOCKED: `miss` increments `err_cnt` (saturates at all-ones) and `mcnt`; `match` clears `mcnt`. When `mcnt` reaches MISS_MAX, go to HUNT and clear `run` and `mcnt`.
- Mismatches in HUNT are never counted in `err_cnt`.
- `err_clr` zeroes `err_cnt`. If `err_clr` and a counted miss occur in the same cycle, the clear wins and the result is 0.
- Cycles with `in_valid` low hold all state; no prediction advance.
- A generator reset mid-stream gives one discontinuity: 1 error, lock kept when MISS_MAX > 1.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_cnt`=0, `zero_det`=0, `prev_ok`=0, FSM=HUNT.
- All outputs are registered. Outputs reflect word k on the cycle after word k is sampled (latency 1).
- First word after reset is never compared.
- Earliest lock: LOCK_CNT+1 valid words after reset, with `locked` high the next cycle.
- Lock drop: `locked` falls the cycle after the MISS_MAX-th consecutive miss. That miss is itself still counted and pulsed.

## Structure
- `prbs_pkg` holds:
  - default `TAPS` constant (shared with `prbs`);
  - state enum `chk_state_t {HUNT, LOCKED}`;
  - a `prbs_next(word, taps)` function.
- Sub-module `prbs_step`: combinational one-step LFSR next-word, parameterised N/TAPS. Used by `prbs_chk`, and reusable by `prbs` so both ends provably share one polynomial.

## Test plan
- Clean stream: drive the `prbs` generator (N=14) into the checker after reset -> `locked` rises on cycle LOCK_CNT+2 = 10 after the first valid word; `err_cnt` stays 0 for 200 cycles.
- Single bit flip: while locked, XOR bit 3 of one word -> `err_pulse` on exactly 2 cycles, because the corrupted word also breaks the next prediction; `err_cnt`=2; `locked` stays 1.
- Burst: force 4 consecutive wrong words while locked -> `err_cnt`=4, `locked` falls after the 4th. Relock 9 clean words later with `err_cnt` still 4.
- Zero word: drive 14'h0000 repeatedly -> `zero_det`=1, never locks, `err_cnt`=0.
- Prediction check: accepted 14'h0001 then 14'h0002 counts as a match; accepted 14'h3802 then 14'h3004 counts as a match.
- Gaps and clears:
  - `in_valid` toggled 50% on a clean stream -> lock achieved, no errors.
  - `err_clr` coincident with a miss -> `err_cnt`=0.
  - `rst_n` pulsed mid-lock -> all outputs return to reset values asynchronously.
